// File: rtl/rv_boot_pkg.sv
// rv_boot_pkg
// Shared definitions for the boot/run sequencer: FSM state encoding,
// host command header codes and load-target encoding.
package rv_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_COUNT = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_RUN   = 3'd5,
        ST_STOP  = 3'd6
    } boot_state_t;

    localparam logic [7:0] CMD_IMEM = 8'h01;
    localparam logic [7:0] CMD_DMEM = 8'h02;
    localparam logic [7:0] CMD_RUN  = 8'h03;

    // Load target selected by the frame header.
    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

endpackage

// File: rtl/rv_boot_word_asm.sv
// rv_boot_word_asm
// Byte-to-word assembler. Bytes arrive little-endian (first byte ends up in
// bits 7:0), so each accepted byte enters at the top and the word shifts down.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clear           restart byte counting (start of a new frame payload)
//   byte_valid      accept byte_data this cycle
//   byte_data       incoming byte
//   word            assembled 32-bit word
//   last_byte       the next accepted byte completes the word
//   word_valid      one-cycle pulse the cycle after the 4th byte is taken
module rv_boot_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        last_byte,
    output logic        word_valid
);

    logic [31:0] word_reg;
    logic [31:0] word_next;
    logic [1:0]  byte_cnt_reg;
    logic        word_valid_reg;

    // Each byte lane takes the lane above it; the newest byte enters lane 3.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign word_next[gi*8 +: 8] = word_reg[(gi+1)*8 +: 8];
        end
    endgenerate
    assign word_next[31:24] = byte_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_reg       <= '0;
            byte_cnt_reg   <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= byte_valid && (byte_cnt_reg == 2'd3);
            if (clear) begin
                byte_cnt_reg <= '0;
            end else if (byte_valid) begin
                word_reg     <= word_next;
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
        end
    end

    assign word       = word_reg;
    assign last_byte  = (byte_cnt_reg == 2'd3);
    assign word_valid = word_valid_reg;

endmodule

// File: rtl/rv_boot_ctrl.sv
// rv_boot_ctrl
// Boot and run sequencer for the pipelined RV core. A host byte stream loads
// IMEM/DMEM while the core is held in reset, then a RUN command releases the
// core until it raises done or a cycle limit expires.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   host_valid/data     host byte stream, host_ready = controller accepts
//   mem_sel             1 = controller owns memory write ports, 0 = core
//   ld_imem_we/dmem_we  load write strobes (only in WRITE)
//   ld_addr, ld_wdata   load byte address and word
//   core_rst_n          active-low reset to the core
//   core_done           done flag from the core wrapper
//   run_done            sticky, last run ended by core_done
//   run_timeout         sticky, last run ended by the cycle limit
//   proto_err           sticky, bad header or out-of-range write
//   cycle_count         core cycles of the last/current run
module rv_boot_ctrl
    import rv_boot_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64,
    parameter int TIMEOUT    = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_valid,
    input  logic [7:0]  host_data,
    output logic        host_ready,
    output logic        mem_sel,
    output logic        ld_imem_we,
    output logic        ld_dmem_we,
    output logic [31:0] ld_addr,
    output logic [31:0] ld_wdata,
    output logic        core_rst_n,
    input  logic        core_done,
    output logic        run_done,
    output logic        run_timeout,
    output logic        proto_err,
    output logic [31:0] cycle_count
);

    localparam logic [31:0] IMEM_DEPTH = 32'(IMEM_WORDS);
    localparam logic [31:0] DMEM_DEPTH = 32'(DMEM_WORDS);
    localparam logic [31:0] TIMEOUT_W  = 32'(TIMEOUT);

    boot_state_t state_reg, state_next;
    logic        target_reg, target_next;
    logic [7:0]  index_reg, index_next;
    logic [7:0]  count_reg, count_next;
    logic        ready_en_reg;
    logic        proto_err_reg, proto_err_next;
    logic        run_done_reg, run_done_next;
    logic        run_timeout_reg, run_timeout_next;
    logic [31:0] cycle_count_reg, cycle_count_next;

    logic        accept;
    logic        in_range;
    logic [31:0] cycle_inc;
    logic [31:0] asm_word;
    logic        asm_last;
    logic        asm_word_valid;

    assign accept = host_valid && host_ready;

    rv_boot_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_reg == ST_COUNT),
        .byte_valid (accept && (state_reg == ST_DATA)),
        .byte_data  (host_data),
        .word       (asm_word),
        .last_byte  (asm_last),
        .word_valid (asm_word_valid)
    );

    // Depth check on the zero-extended index, so wrapped indices are checked too.
    assign in_range = (target_reg == TGT_IMEM) ? ({24'd0, index_reg} < IMEM_DEPTH)
                                               : ({24'd0, index_reg} < DMEM_DEPTH);

    // Saturating run-cycle increment.
    assign cycle_inc = (cycle_count_reg == 32'hFFFF_FFFF) ? cycle_count_reg
                                                          : cycle_count_reg + 32'd1;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            target_reg      <= TGT_IMEM;
            index_reg       <= '0;
            count_reg       <= '0;
            ready_en_reg    <= 1'b0;
            proto_err_reg   <= 1'b0;
            run_done_reg    <= 1'b0;
            run_timeout_reg <= 1'b0;
            cycle_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            target_reg      <= target_next;
            index_reg       <= index_next;
            count_reg       <= count_next;
            ready_en_reg    <= 1'b1;
            proto_err_reg   <= proto_err_next;
            run_done_reg    <= run_done_next;
            run_timeout_reg <= run_timeout_next;
            cycle_count_reg <= cycle_count_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next       = state_reg;
        target_next      = target_reg;
        index_next       = index_reg;
        count_next       = count_reg;
        proto_err_next   = proto_err_reg;
        run_done_next    = run_done_reg;
        run_timeout_next = run_timeout_reg;
        cycle_count_next = cycle_count_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (host_data)
                        CMD_IMEM: begin
                            target_next = TGT_IMEM;
                            state_next  = ST_ADDR;
                        end
                        CMD_DMEM: begin
                            target_next = TGT_DMEM;
                            state_next  = ST_ADDR;
                        end
                        CMD_RUN: begin
                            run_done_next    = 1'b0;
                            run_timeout_next = 1'b0;
                            cycle_count_next = '0;
                            state_next       = ST_RUN;
                        end
                        default: proto_err_next = 1'b1;
                    endcase
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    index_next = host_data;
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    if (host_data == 8'd0) begin
                        state_next = ST_IDLE;
                    end else begin
                        count_next = host_data;
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept && asm_last) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!in_range) begin
                    proto_err_next = 1'b1;
                end
                index_next = index_reg + 8'd1;
                count_next = count_reg - 8'd1;
                state_next = (count_reg == 8'd1) ? ST_IDLE : ST_DATA;
            end
            ST_RUN: begin
                cycle_count_next = cycle_inc;
                // core_done takes priority over a coincident timeout.
                if (core_done) begin
                    run_done_next = 1'b1;
                    state_next    = ST_STOP;
                end else if (cycle_inc >= TIMEOUT_W) begin
                    run_timeout_next = 1'b1;
                    state_next       = ST_STOP;
                end
            end
            ST_STOP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        host_ready = 1'b0;
        mem_sel    = 1'b1;
        core_rst_n = 1'b0;
        ld_imem_we = 1'b0;
        ld_dmem_we = 1'b0;
        ld_addr    = '0;
        ld_wdata   = '0;

        case (state_reg)
            ST_IDLE, ST_ADDR, ST_COUNT, ST_DATA: begin
                host_ready = ready_en_reg;
            end
            ST_WRITE: begin
                ld_imem_we = asm_word_valid && in_range && (target_reg == TGT_IMEM);
                ld_dmem_we = asm_word_valid && in_range && (target_reg == TGT_DMEM);
                ld_addr    = {22'd0, index_reg, 2'b00};
                ld_wdata   = asm_word;
            end
            ST_RUN: begin
                mem_sel    = 1'b0;
                core_rst_n = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign run_done    = run_done_reg;
    assign run_timeout = run_timeout_reg;
    assign proto_err   = proto_err_reg;
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_rv_boot_ctrl.sv
module tb_rv_boot_ctrl;

    logic        clk;
    logic        rst;
    logic        host_valid;
    logic [7:0]  host_data;
    logic        host_ready;
    logic        mem_sel;
    logic        ld_imem_we;
    logic        ld_dmem_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        core_rst_n;
    logic        core_done;
    logic        run_done;
    logic        run_timeout;
    logic        proto_err;
    logic [31:0] cycle_count;

    int compared;
    int mismatched;

    rv_boot_ctrl #(
        .IMEM_WORDS (64),
        .DMEM_WORDS (64),
        .TIMEOUT    (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .mem_sel     (mem_sel),
        .ld_imem_we  (ld_imem_we),
        .ld_dmem_we  (ld_dmem_we),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .core_rst_n  (core_rst_n),
        .core_done   (core_done),
        .run_done    (run_done),
        .run_timeout (run_timeout),
        .proto_err   (proto_err),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        host_valid = 1'b1;
        host_data  = b;
        while (host_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_wait", {31'd0, host_ready}, 32'd1);
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_ready",   {31'd0, host_ready},  32'd0);
        chk("rst_core_n",  {31'd0, core_rst_n},  32'd0);
        chk("rst_mem_sel", {31'd0, mem_sel},     32'd1);
        chk("rst_imem_we", {31'd0, ld_imem_we},  32'd0);
        chk("rst_dmem_we", {31'd0, ld_dmem_we},  32'd0);
        chk("rst_addr",    ld_addr,              32'd0);
        chk("rst_wdata",   ld_wdata,             32'd0);
        chk("rst_perr",    {31'd0, proto_err},   32'd0);
        chk("rst_done",    {31'd0, run_done},    32'd0);
        chk("rst_tmo",     {31'd0, run_timeout}, 32'd0);
        chk("rst_cycles",  cycle_count,          32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        host_valid = 1'b0;
        host_data  = 8'h00;
        core_done  = 1'b0;

        // Power-on reset
        do_reset();
        chk("ready_after", {31'd0, host_ready}, 32'd1);

        // Reset mid-DATA after two payload bytes
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB);
        do_reset();
        send_byte(8'h01); send_byte(8'h05); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("fresh_we",    {31'd0, ld_imem_we}, 32'd1);
        chk("fresh_addr",  ld_addr,             32'h0000_0014);
        chk("fresh_data",  ld_wdata,            32'h4433_2211);

        // IMEM load of two words
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        chk("im0_we",      {31'd0, ld_imem_we}, 32'd1);
        chk("im0_dwe",     {31'd0, ld_dmem_we}, 32'd0);
        chk("im0_addr",    ld_addr,             32'h0000_0000);
        chk("im0_data",    ld_wdata,            32'h0050_0093);
        chk("im0_ready",   {31'd0, host_ready}, 32'd0);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'hA0); send_byte(8'h00);
        chk("im1_we",      {31'd0, ld_imem_we}, 32'd1);
        chk("im1_dwe",     {31'd0, ld_dmem_we}, 32'd0);
        chk("im1_addr",    ld_addr,             32'h0000_0004);
        chk("im1_data",    ld_wdata,            32'h00A0_0113);
        @(negedge clk);
        chk("im_idle_we",  {31'd0, ld_imem_we}, 32'd0);
        chk("im_idle_rdy", {31'd0, host_ready}, 32'd1);
        chk("im_perr",     {31'd0, proto_err},  32'd0);

        // DMEM range: index 63 writes, index 64 is suppressed
        send_byte(8'h02); send_byte(8'h3F); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("dm63_we",     {31'd0, ld_dmem_we}, 32'd1);
        chk("dm63_iwe",    {31'd0, ld_imem_we}, 32'd0);
        chk("dm63_addr",   ld_addr,             32'h0000_00FC);
        chk("dm63_data",   ld_wdata,            32'h0403_0201);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        chk("dm64_we",     {31'd0, ld_dmem_we}, 32'd0);
        chk("dm64_addr",   ld_addr,             32'h0000_0100);
        @(negedge clk);
        chk("dm64_perr",   {31'd0, proto_err},  32'd1);

        // Zero-count frame returns to IDLE; bad header flags an error
        do_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        chk("n0_perr",     {31'd0, proto_err},  32'd0);
        send_byte(8'h7F);
        chk("bad_perr",    {31'd0, proto_err},  32'd1);
        chk("bad_ready",   {31'd0, host_ready}, 32'd1);

        // Run ended by core_done after 20 cycles, host byte held meanwhile
        do_reset();
        send_byte(8'h03);
        chk("run_core_n",  {31'd0, core_rst_n}, 32'd1);
        chk("run_memsel",  {31'd0, mem_sel},    32'd0);
        chk("run_cyc0",    cycle_count,         32'd0);
        host_valid = 1'b1;
        host_data  = 8'h7F;
        chk("run_ready",   {31'd0, host_ready}, 32'd0);
        repeat (19) @(negedge clk);
        chk("run_cyc19",   cycle_count,         32'd19);
        core_done = 1'b1;
        @(negedge clk);
        host_valid = 1'b0;
        core_done  = 1'b0;
        chk("stop_done",   {31'd0, run_done},    32'd1);
        chk("stop_tmo",    {31'd0, run_timeout}, 32'd0);
        chk("stop_cycles", cycle_count,          32'd20);
        chk("stop_core_n", {31'd0, core_rst_n},  32'd0);
        chk("stop_memsel", {31'd0, mem_sel},     32'd1);
        @(negedge clk);
        chk("idle_cycles", cycle_count,          32'd20);
        chk("idle_perr",   {31'd0, proto_err},   32'd0);
        chk("idle_ready",  {31'd0, host_ready},  32'd1);

        // Timeout run; second RUN clears the flags and the counter
        send_byte(8'h03);
        chk("t_done_clr",  {31'd0, run_done},    32'd0);
        chk("t_cyc0",      cycle_count,          32'd0);
        repeat (49) @(negedge clk);
        chk("t_core_n49",  {31'd0, core_rst_n},  32'd1);
        @(negedge clk);
        chk("t_tmo",       {31'd0, run_timeout}, 32'd1);
        chk("t_done",      {31'd0, run_done},    32'd0);
        chk("t_cycles",    cycle_count,          32'd50);
        chk("t_core_n",    {31'd0, core_rst_n},  32'd0);
        @(negedge clk);

        // core_done coincident with the final timeout cycle
        send_byte(8'h03);
        chk("c_tmo_clr",   {31'd0, run_timeout}, 32'd0);
        repeat (49) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("c_done",      {31'd0, run_done},    32'd1);
        chk("c_tmo",       {31'd0, run_timeout}, 32'd0);
        chk("c_cycles",    cycle_count,          32'd50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rv_boot_ctrl.md
Name: rv_boot_ctrl

Overview:
Boot and run sequencer for the pipelined RV core (rv_pl_wrapper) and its external IMEM/DMEM BRAMs. Accepts a byte-stream command protocol from a host link. Loads IMEM/DMEM while the core is held in reset, then releases the core and monitors done_flag. Reports completion, timeout and cycle count. Sits between the host interface (UART/debug) and the wrapper plus BRAM port muxes.

Parameters:
IMEM_WORDS, 64, IMEM depth in 32-bit words
DMEM_WORDS, 64, DMEM depth in 32-bit words
TIMEOUT, 10000, max run cycles before forced stop (must be >=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
host_valid  in  1  host byte valid
host_data  in  8  host byte
host_ready  out  1  controller accepts byte (transfer = valid & ready)
mem_sel  out  1  1 = controller owns IMEM/DMEM write ports; 0 = core owns them
ld_imem_we  out  1  IMEM write strobe
ld_dmem_we  out  1  DMEM write strobe
ld_addr  out  32  byte address (word index << 2)
ld_wdata  out  32  write word
core_rst_n  out  1  active-low reset to the core
core_done  in  1  done_flag from the wrapper
run_done  out  1  sticky: run ended via core_done
run_timeout  out  1  sticky: run ended via TIMEOUT
proto_err  out  1  sticky: bad header or out-of-range write
cycle_count  out  32  core cycles of the last/current run

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, core_rst_n=0, mem_sel=1, host_ready=0 for the reset cycle then 1, all strobes 0, ld_addr=0, ld_wdata=0, all flags 0, cycle_count=0. Reset mid-load or mid-run aborts immediately; the partial word is discarded.
- Protocol: header byte 0x01 = load IMEM, 0x02 = load DMEM, 0x03 = RUN.
  - Load frame: header, start word index (8b), word count N (8b), then 4N data bytes, little-endian (first byte = bits 7:0).
- States: IDLE, ADDR, COUNT, DATA, WRITE, RUN, STOP.
- IDLE: host_ready=1.
  - 0x01/0x02: latch target, go to ADDR.
  - 0x03: clear run_done, run_timeout and cycle_count; go to RUN.
  - Any other byte: dropped, proto_err=1, stay in IDLE.
- ADDR: latch index, go to COUNT.
- COUNT: N=0 returns to IDLE with no writes; otherwise latch N and go to DATA.
- DATA: shift bytes into a 32-bit assembly register; the 4th byte moves to WRITE.
- WRITE: exactly 1 cycle, host_ready=0.
  - Strobe of the selected target =1, ld_addr=index<<2, ld_wdata=assembled word.
  - If index >= the target's depth: strobe is suppressed and proto_err=1.
  - index increments (8-bit, wraps 255->0; wrapped writes obey the same depth check). N decrements.
  - N=0 goes to IDLE, else DATA.
- Only WRITE asserts a strobe. ld_imem_we and ld_dmem_we are never asserted together.
- RUN:
  - Entry cycle: mem_sel=0 and core_rst_n=1, registered (core leaves reset one cycle after the RUN byte is accepted).
  - host_ready=0.
  - cycle_count increments every RUN cycle, saturating at 2^32-1.
  - core_done=1 sampled: go to STOP, set run_done.
  - Else cycle_count reaching TIMEOUT: go to STOP, set run_timeout.
  - If both occur in the same cycle, core_done wins (run_done=1, run_timeout=0).
- STOP: 1 cycle.
  - core_rst_n=0, mem_sel=1, cycle_count frozen.
  - Go to IDLE. Flags hold until the next RUN header or reset.
- Latency: byte→next state 1 cycle; last data byte→write strobe 1 cycle; RUN byte→core_rst_n high 1 cycle.
- host_valid is ignored when host_ready=0. The host must hold the byte until it is accepted.

Decomposition:
- Shared package rv_boot_pkg:
  - State encoding constants.
  - Header codes CMD_IMEM=8'h01, CMD_DMEM=8'h02, CMD_RUN=8'h03.
- One natural sub-module, rv_boot_word_asm: byte-to-word shift register with a byte counter and a word_valid pulse.
- The FSM, counters and flags stay in the top.

Test Plan:
- Reset: rst low mid-DATA (after 2 bytes) → all outputs at reset values, core_rst_n=0. A following fresh IMEM frame writes correct words with no stale bytes.
- IMEM load: 01 00 02 | 93 00 50 00 | 13 01 A0 00 → ld_imem_we pulses twice: addr 0x0 data 0x00500093, addr 0x4 data 0x00A00113. ld_dmem_we stays 0.
- Range: 02 3F 02 + 8 bytes → the write at index 63 (addr 0xFC) occurs; the index-64 write is suppressed; proto_err=1. Header 0x7F in IDLE also sets proto_err.
- Run/done: RUN, bench raises core_done 20 cycles after core_rst_n rises → run_done=1, run_timeout=0, cycle_count=20, core_rst_n=0 and mem_sel=1 one cycle later.
- Timeout: TIMEOUT=50, core_done never asserted → run_timeout=1, cycle_count=50. core_done coincident with cycle 50 → run_done=1 only.
- Back-pressure: host_valid held high during WRITE/RUN → no byte consumed. A second RUN clears flags and restarts cycle_count at 0.
